// File: rtl/jtag_master_pkg.sv
// Shared op codes, FSM states and the fixed TMS header/tail patterns of the JTAG master.
package jtag_master_pkg;

  typedef enum logic [1:0] {
    OP_RESET = 2'b00,
    OP_IR    = 2'b01,
    OP_DR    = 2'b10,
    OP_RUN   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_BODY,
    ST_TAIL,
    ST_DONE
  } state_e;

  // Patterns are stored LSB-first: bit k is the TMS value of slot k.
  localparam logic [3:0] HDR_IR_TMS     = 4'b0011;  // RTI->SelDR->SelIR->CapIR->ShIR
  localparam logic [3:0] HDR_DR_TMS     = 4'b0001;  // RTI->SelDR->CapDR->ShDR
  localparam logic [1:0] TAIL_SH_TMS    = 2'b01;    // Exit1->Update->RTI
  localparam int         RESET_BODY_LEN = 5;        // five TMS=1 reach Test-Logic-Reset

  function automatic logic [2:0] hdr_len(op_e op);
    case (op)
      OP_IR:   return 3'd4;
      OP_DR:   return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] tail_len(op_e op);
    case (op)
      OP_RESET:     return 3'd1;
      OP_IR, OP_DR: return 3'd2;
      default:      return 3'd0;
    endcase
  endfunction

  function automatic logic hdr_tms(op_e op, logic [1:0] idx);
    return (op == OP_IR) ? HDR_IR_TMS[idx] : HDR_DR_TMS[idx];
  endfunction

  // RESET leaves Test-Logic-Reset with a single TMS=0 slot.
  function automatic logic tail_tms(op_e op, logic idx);
    return (op == OP_RESET) ? 1'b0 : TAIL_SH_TMS[idx];
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK generator: DIV clk low phase then DIV clk high phase per slot.
// 'fall' is high in the clk cycle whose closing edge drives tck low, so the
// FSM can launch the next slot and sample TDO on that same edge.
module jtag_tck_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tck,
  output logic fall
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;
  logic          active, wrap;

  // Keep counting while a high phase is open so tck only stops low.
  always_comb begin
    active = run | tck_q;
    wrap   = (cnt_q == LAST);
    cnt_d  = cnt_q;
    tck_d  = tck_q;
    if (active) begin
      if (wrap) begin
        cnt_d = '0;
        tck_d = ~tck_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Phase counter and tck register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck  = tck_q;
  assign fall = tck_q & wrap;

endmodule

// File: rtl/jtag_shift_master.sv
// JTAG master: sequences the TAP through RESET / SHIFT_IR / SHIFT_DR / RUNTEST
// commands, one at a time, always starting and ending in Run-Test/Idle.
module jtag_shift_master
  import jtag_master_pkg::*;
#(
  parameter  int DIV     = 4,
  parameter  int MAX_LEN = 32,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int IDX_W = $clog2(MAX_LEN);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [LEN_W-1:0]   len_q, len_d;    // remaining BODY slots, last one at 1
  logic [LEN_W-1:0]   idx_q, idx_d;    // slot index in HDR/TAIL, bit index in BODY
  logic [MAX_LEN-1:0] tx_q, tx_d;
  logic [MAX_LEN-1:0] rx_q, rx_d;
  logic               tap_known_q, tap_known_d;
  logic               err_q, err_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               slot_start;
  logic               run, fall;

  assign run = (state_q == ST_HDR) || (state_q == ST_BODY) || (state_q == ST_TAIL);

  jtag_tck_gen #(.DIV(DIV)) u_tck (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .tck  (tck),
    .fall (fall)
  );

  // Command acceptance, slot sequencing and TMS/TDI for the slot being launched.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    idx_d       = idx_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    tap_known_d = tap_known_q;
    err_d       = err_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    slot_start  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
        if (cmd_valid) begin
          op_d  = op_e'(cmd_op);
          idx_d = '0;
          rx_d  = '0;
          tx_d  = cmd_data;
          len_d = cmd_len;
          if (op_d == OP_RESET) begin
            len_d      = LEN_W'(RESET_BODY_LEN);
            state_d    = ST_BODY;
            slot_start = 1'b1;
          end else if (!tap_known_q || cmd_len == '0 || cmd_len > LEN_W'(MAX_LEN)) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            state_d    = (hdr_len(op_d) != 3'd0) ? ST_HDR : ST_BODY;
            slot_start = 1'b1;
          end
        end
      end
      ST_HDR: if (fall) begin
        slot_start = 1'b1;
        if (idx_q == LEN_W'(hdr_len(op_q) - 3'd1)) begin
          state_d = ST_BODY;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + LEN_W'(1);
        end
      end
      ST_BODY: if (fall) begin
        if (op_q == OP_IR || op_q == OP_DR) rx_d[idx_q[IDX_W-1:0]] = tdo;
        tx_d = tx_q >> 1;
        if (len_q == LEN_W'(1)) begin
          idx_d = '0;
          if (tail_len(op_q) != 3'd0) begin
            state_d    = ST_TAIL;
            slot_start = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          len_d      = len_q - LEN_W'(1);
          idx_d      = idx_q + LEN_W'(1);
          slot_start = 1'b1;
        end
      end
      ST_TAIL: if (fall) begin
        if (idx_q == LEN_W'(tail_len(op_q) - 3'd1)) begin
          state_d = ST_DONE;
          if (op_q == OP_RESET) tap_known_d = 1'b1;
        end else begin
          idx_d      = idx_q + LEN_W'(1);
          slot_start = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // TMS/TDI change only on the edge that opens a slot; otherwise they hold.
    if (slot_start) begin
      tdi_d = 1'b0;
      case (state_d)
        ST_HDR:  tms_d = hdr_tms(op_d, idx_d[1:0]);
        ST_BODY: begin
          case (op_d)
            OP_RESET: tms_d = 1'b1;
            OP_RUN:   tms_d = 1'b0;
            default: begin
              tms_d = (len_d == LEN_W'(1));
              tdi_d = tx_d[0];
            end
          endcase
        end
        default: tms_d = tail_tms(op_d, idx_d[0]);
      endcase
    end
  end

  // State and datapath registers; reset drops any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_RESET;
      len_q       <= '0;
      idx_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      tap_known_q <= 1'b0;
      err_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      tap_known_q <= tap_known_d;
      err_q       <= err_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy      = ~cmd_ready;
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_data  = rx_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_shift_master.sv
// Directed bench for jtag_shift_master with a behavioural TAP (IDCODE instr 7).
module tb_jtag_shift_master;

  localparam logic [31:0] IDCODE = 32'h1234_5679;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT with DIV=4 driving the TAP model
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [5:0]  cmd_len = 6'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid, rsp_err, busy, tck, tms, tdi;
  logic [31:0] rsp_data;
  logic        tdo = 1'b0;

  jtag_shift_master #(.DIV(4), .MAX_LEN(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_data(rsp_data), .busy(busy), .tck(tck), .tms(tms),
    .tdi(tdi), .tdo(tdo));

  // DUT with DIV=1 for the back-to-back command case
  logic        c1_valid = 1'b0, c1_ready;
  logic [1:0]  c1_op = 2'd0;
  logic [5:0]  c1_len = 6'd0;
  logic [31:0] c1_data = 32'd0;
  logic        c1_rsp_valid, c1_rsp_err, c1_busy, c1_tck, c1_tms, c1_tdi;
  logic [31:0] c1_rsp_data;
  logic        c1_tdo = 1'b0;

  jtag_shift_master #(.DIV(1), .MAX_LEN(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
    .cmd_op(c1_op), .cmd_len(c1_len), .cmd_data(c1_data), .rsp_valid(c1_rsp_valid),
    .rsp_err(c1_rsp_err), .rsp_data(c1_rsp_data), .busy(c1_busy), .tck(c1_tck),
    .tms(c1_tms), .tdi(c1_tdi), .tdo(c1_tdo));

  // ---------------- TAP model ----------------
  typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PDR, EX2DR, UPDR,
                            SELIR, CAPIR, SHIR, EX1IR, PIR, EX2IR, UPIR} tap_e;
  tap_e        ts = PDR;
  logic [3:0]  ir = 4'h7, ir_sr = 4'h0;
  logic [31:0] dr_sr = 32'h0;
  logic        bp = 1'b0;

  function automatic tap_e tap_next(tap_e s, logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PDR;
      PDR:   return m ? EX2DR : PDR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PIR;
      PIR:   return m ? EX2IR : PIR;
      EX2IR: return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    case (ts)
      TLR:   ir <= 4'h7;
      CAPDR: if (ir == 4'h7) dr_sr <= IDCODE; else bp <= 1'b0;
      SHDR:  if (ir == 4'h7) dr_sr <= {tdi, dr_sr[31:1]}; else bp <= tdi;
      CAPIR: ir_sr <= 4'b0001;
      SHIR:  ir_sr <= {tdi, ir_sr[3:1]};
      UPIR:  ir <= ir_sr;
      default: ;
    endcase
    ts <= tap_next(ts, tms);
  end

  always @(negedge tck)
    tdo <= (ts == SHDR) ? ((ir == 4'h7) ? dr_sr[0] : bp) : (ts == SHIR) ? ir_sr[0] : 1'b0;

  // ---------------- checking ----------------
  int nvec = 0, nfail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one command to u_dut and observe tck/tms/tdi per slot until the response.
  task automatic do_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                        output logic err, output logic [31:0] rdata, output int rises,
                        output logic [63:0] tmsl, output logic [63:0] tdil,
                        output int lat, output int since, output logic tmo);
    logic prev;
    int   g;
    err = 1'b0; rdata = '0; rises = 0; tmsl = '0; tdil = '0; lat = 0; since = 0; tmo = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
    g = 0;
    while (!cmd_ready && g < 200) begin @(negedge clk); g++; end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    prev = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      lat++;
      if (tck && !prev) begin
        if (rises < 64) begin tmsl[rises] = tms; tdil[rises] = tdi; end
        rises++;
        since = 0;
      end else begin
        since++;
      end
      prev = tck;
      if (rsp_valid) begin
        err = rsp_err; rdata = rsp_data; tmo = 1'b0;
        break;
      end
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  len;
    logic [31:0] data;
    logic        err;
    int          tcks;
    logic [63:0] tms;
    logic [63:0] tdi;
    logic [31:0] rdata;
  } vec_t;

  function automatic vec_t mkv(logic [1:0] op, logic [5:0] len, logic [31:0] data, logic err,
                               int tcks, logic [63:0] tmsv, logic [63:0] tdiv, logic [31:0] rd);
    vec_t v;
    v.op = op; v.len = len; v.data = data; v.err = err; v.tcks = tcks;
    v.tms = tmsv; v.tdi = tdiv; v.rdata = rd;
    return v;
  endfunction

  vec_t vt[9];

  initial begin
    logic        e, tmo;
    logic [31:0] rd;
    logic [63:0] tl, dl;
    int          nr, lat, since, g;
    int          r_at[8];
    logic        prev;
    bit          seen;

    //              op     len    data           err tck tms-log (LSB first)   tdi-log       rsp_data
    vt[0] = mkv(2'b00, 6'd0,  32'h0,         0,  6,  64'h1F,               64'h0,        32'h0);
    vt[1] = mkv(2'b01, 6'd4,  32'h7,         0, 10,  64'h183,              64'h70,       32'h1);
    vt[2] = mkv(2'b10, 6'd32, 32'h0,         0, 37,  64'hC_0000_0001,      64'h0,        IDCODE);
    vt[3] = mkv(2'b10, 6'd0,  32'hFFFF_FFFF, 1,  0,  64'h0,                64'h0,        32'h0);
    vt[4] = mkv(2'b10, 6'd33, 32'hFFFF_FFFF, 1,  0,  64'h0,                64'h0,        32'h0);
    vt[5] = mkv(2'b10, 6'd8,  32'hA5,        0, 13,  64'hC01,              64'h528,      32'h79);
    vt[6] = mkv(2'b11, 6'd3,  32'hFFFF_FFFF, 0,  3,  64'h0,                64'h0,        32'h0);
    vt[7] = mkv(2'b01, 6'd4,  32'hF,         0, 10,  64'h183,              64'hF0,       32'h1);
    vt[8] = mkv(2'b10, 6'd4,  32'hA,         0,  9,  64'hC1,               64'h50,       32'h4);

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_tck", tck, 0);
    chk("rst_tms", tms, 1);
    chk("rst_tdi", tdi, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    rst_n = 1'b1;

    // Shift before any RESET is rejected without touching tck
    do_cmd(2'b10, 6'd8, 32'h0, e, rd, nr, tl, dl, lat, since, tmo);
    chk("pre_reset_timeout", tmo, 0);
    chk("pre_reset_err", e, 1);
    chk("pre_reset_tcks", nr, 0);
    chk("pre_reset_latency", lat, 1);

    for (int i = 0; i < 9; i++) begin
      do_cmd(vt[i].op, vt[i].len, vt[i].data, e, rd, nr, tl, dl, lat, since, tmo);
      chk($sformatf("v%0d_timeout", i), tmo, 0);
      chk($sformatf("v%0d_err", i), e, vt[i].err);
      chk($sformatf("v%0d_tcks", i), nr, vt[i].tcks);
      chk($sformatf("v%0d_tms", i), tl, vt[i].tms);
      chk($sformatf("v%0d_tdi", i), dl, vt[i].tdi);
      chk($sformatf("v%0d_rsp_data", i), rd, vt[i].rdata);
      if (vt[i].err) chk($sformatf("v%0d_err_latency", i), lat, 1);
      else begin
        chk($sformatf("v%0d_rsp_after_rise", i), since, 4);
        chk($sformatf("v%0d_tap_rti", i), ts, RTI);
      end
      if (i == 1) chk("ir_after_idcode", ir, 4'h7);
    end
    chk("ir_after_bypass", ir, 4'hF);

    // rst_n during DR BODY slot 10: outputs reset at once, no response, tap_known lost
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 6'd32; cmd_data = 32'h0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    nr = 0; prev = 1'b0; seen = 0; g = 0;
    while (nr < 14 && g < 3000) begin
      @(negedge clk);
      if (tck && !prev) nr++;
      if (rsp_valid) seen = 1;
      prev = tck; g++;
    end
    chk("midrst_reached_slot", nr, 14);
    rst_n = 1'b0;
    #1;
    chk("midrst_tck", tck, 0);
    chk("midrst_tms", tms, 1);
    chk("midrst_ready", cmd_ready, 1);
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    chk("midrst_no_rsp", seen, 0);
    rst_n = 1'b1;
    do_cmd(2'b01, 6'd4, 32'h7, e, rd, nr, tl, dl, lat, since, tmo);
    chk("post_midrst_ir_err", e, 1);
    chk("post_midrst_ir_tcks", nr, 0);

    // DIV=1: RESET then RUNTEST 3 with cmd_valid held throughout
    @(negedge clk);
    c1_valid = 1'b1; c1_op = 2'b00; c1_len = 6'd0;
    @(posedge clk);
    #1 c1_op = 2'b11; c1_len = 6'd3;
    nr = 0; prev = 1'b0; tmo = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c1_tck && !prev) nr++;
      prev = c1_tck;
      if (c1_rsp_valid) begin tmo = 1'b0; break; end
    end
    chk("div1_reset_timeout", tmo, 0);
    chk("div1_reset_err", c1_rsp_err, 0);
    chk("div1_reset_tcks", nr, 6);
    chk("div1_ready_in_rsp", c1_ready, 1);
    @(posedge clk);
    #1 c1_valid = 1'b0;
    nr = 0; prev = 1'b0; tmo = 1'b1; tl = '0;
    for (int c = 1; c < 100; c++) begin
      @(negedge clk);
      if (c == 1) chk("div1_run_accepted", c1_busy, 1);
      if (c1_tck && !prev) begin
        if (nr < 8) begin r_at[nr] = c; tl[nr] = c1_tms; end
        nr++;
      end
      prev = c1_tck;
      if (c1_rsp_valid) begin tmo = 1'b0; break; end
    end
    chk("div1_run_timeout", tmo, 0);
    chk("div1_run_err", c1_rsp_err, 0);
    chk("div1_run_data", c1_rsp_data, 0);
    chk("div1_run_tcks", nr, 3);
    chk("div1_run_tms", tl, 0);
    if (nr >= 2) chk("div1_tck_period", r_at[1] - r_at[0], 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
